// File: rtl/dma_pkg.sv
// Shared definitions for the layer DMA read responder: bus widths and the
// FSM state encoding used by dma_engineer_rd.
package dma_pkg;

  localparam int DMA_ADDR_W = 27;
  localparam int DMA_DATA_W = 512;

  localparam logic [1:0] DMA_ST_IDLE  = 2'd0;
  localparam logic [1:0] DMA_ST_ISSUE = 2'd1;
  localparam logic [1:0] DMA_ST_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = DMA_ST_IDLE,
    ST_ISSUE = DMA_ST_ISSUE,
    ST_DRAIN = DMA_ST_DRAIN
  } dma_state_e;

  // Memory beat address for a request: offset by the instance base, wrapping
  // silently at the address width.
  function automatic logic [DMA_ADDR_W-1:0] dma_beat_addr(
    input logic [DMA_ADDR_W-1:0] start_addr,
    input logic [DMA_ADDR_W-1:0] base_addr
  );
    return start_addr + base_addr;
  endfunction

endpackage

// File: rtl/dma_engineer_rd.sv
// Responder side of the layer DMA handshake: accepts one weight-fetch request,
// issues beat reads to memory and forwards the returned beats with an eop marker.
module dma_engineer_rd
  import dma_pkg::*;
#(
  parameter int ADDR_W    = DMA_ADDR_W,
  parameter int DATA_W    = DMA_DATA_W,
  parameter int MAX_OUTST = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dma_engineer_req,
  input  logic [ADDR_W-1:0] dma_engineer_start_addr,
  input  logic [ADDR_W-1:0] dma_engineer_length,
  output logic              dma_engineer_ack,
  output logic [DATA_W-1:0] dma_engineer_dout,
  output logic              dma_engineer_dout_en,
  output logic              dma_engineer_dout_eop,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_rdy,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data
);

  localparam int OUTST_W = $clog2(MAX_OUTST) + 1;
  localparam logic [OUTST_W-1:0] MAX_OUTST_V = OUTST_W'(MAX_OUTST);
  localparam logic [ADDR_W-1:0]  BASE_V      = ADDR_W'(BASE_ADDR);

  dma_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   issue_left_q, issue_left_d;
  logic [ADDR_W-1:0]   ret_left_q, ret_left_d;
  logic [OUTST_W-1:0]  outst_q, outst_d;
  logic                zero_q, zero_d;
  logic                ack_q, ack_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                dout_en_q, dout_en_d;
  logic                eop_q, eop_d;

  logic issue_fire;
  logic ret_fire;

  assign mem_rd_req = (state_q == ST_ISSUE) && (issue_left_q != '0) &&
                      (outst_q < MAX_OUTST_V);
  assign mem_rd_addr = addr_q;

  assign issue_fire = mem_rd_req && mem_rd_rdy;
  // Returns with nothing left to receive are strays (e.g. after a reset) and are dropped.
  assign ret_fire   = mem_rd_valid && (ret_left_q != '0);

  assign dma_engineer_ack      = ack_q;
  assign dma_engineer_dout     = dout_q;
  assign dma_engineer_dout_en  = dout_en_q;
  assign dma_engineer_dout_eop = eop_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    issue_left_d = issue_left_q;
    ret_left_d   = ret_left_q;
    outst_d      = outst_q;
    zero_d       = zero_q;
    ack_d        = 1'b0;
    dout_d       = dout_q;
    dout_en_d    = 1'b0;
    eop_d        = 1'b0;

    if (ret_fire) begin
      dout_en_d  = 1'b1;
      dout_d     = mem_rd_data;
      ret_left_d = ret_left_q - 1'b1;
      eop_d      = (ret_left_q == ADDR_W'(1));
    end

    if (issue_fire && !ret_fire) begin
      outst_d = outst_q + 1'b1;
    end else if (!issue_fire && ret_fire && (outst_q != '0)) begin
      outst_d = outst_q - 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (dma_engineer_req) begin
          ack_d        = 1'b1;
          addr_d       = dma_beat_addr(dma_engineer_start_addr, BASE_V);
          issue_left_d = dma_engineer_length;
          ret_left_d   = dma_engineer_length;
          zero_d       = (dma_engineer_length == '0);
          // Zero-length requests pass through DRAIN so the eop pulse trails the ack.
          state_d      = (dma_engineer_length == '0) ? ST_DRAIN : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (issue_fire) begin
          addr_d       = addr_q + 1'b1;
          issue_left_d = issue_left_q - 1'b1;
          if (issue_left_q == ADDR_W'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (ret_left_q == '0) begin
          state_d = ST_IDLE;
          zero_d  = 1'b0;
          if (zero_q) begin
            eop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      issue_left_q <= '0;
      ret_left_q   <= '0;
      outst_q      <= '0;
      zero_q       <= 1'b0;
      ack_q        <= 1'b0;
      dout_q       <= '0;
      dout_en_q    <= 1'b0;
      eop_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_left_q <= issue_left_d;
      ret_left_q   <= ret_left_d;
      outst_q      <= outst_d;
      zero_q       <= zero_d;
      ack_q        <= ack_d;
      dout_q       <= dout_d;
      dout_en_q    <= dout_en_d;
      eop_q        <= eop_d;
    end
  end

endmodule
